// File: rtl/param_sync_ram_if.sv
// Bus bundle for param_sync_ram: request/ready handshake, write data with
// byte enables, and the registered read return path.
interface param_sync_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic                  req;
  logic                  wnr;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data;
  logic [DATA_W/8-1:0]   be;
  logic                  ready;
  logic [DATA_W-1:0]     q;
  logic                  q_valid;
  logic                  busy;

  // Bus master drives requests and observes the return path.
  modport master (
    output req, wnr, addr, data, be,
    input  ready, q, q_valid, busy
  );

  // The RAM consumes requests and produces the return path.
  modport slave (
    input  req, wnr, addr, data, be,
    output ready, q, q_valid, busy
  );
endinterface

// File: rtl/param_sync_ram.sv
// Parametrised single-port synchronous RAM with request/ready handshake,
// per-byte write enables, a one-cycle registered read with valid strobe and
// an optional post-reset sweep that fills every word with INIT_VAL.
module param_sync_ram #(
  parameter int                 DATA_W         = 8,
  parameter int                 ADDR_W         = 6,
  parameter int                 CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0]  INIT_VAL       = '0
) (
  input  logic            clk,
  input  logic            rst,
  param_sync_ram_if.slave bus
);

  localparam int NUM_BYTES = DATA_W / 8;
  localparam int DEPTH     = 1 << ADDR_W;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;
  logic [DATA_W-1:0] r_q;
  logic              r_q_valid;

  logic              w_accept;
  logic              w_write;
  logic              w_read;
  logic              w_last;

  // An access only happens when the block advertises ready; otherwise the
  // bus fields are never looked at, so they may carry garbage.
  assign w_accept = r_ready & bus.req;
  assign w_write  = w_accept & bus.wnr;
  assign w_read   = w_accept & ~bus.wnr;
  assign w_last   = (r_cnt == {ADDR_W{1'b1}});

  assign bus.ready   = r_ready;
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.busy    = (r_state == S_CLEAR);

  // Control FSM: sweep counter in CLEAR, ready flag raised when IDLE begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        default: begin
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage: sweep writes whole words, bus writes touch only enabled bytes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_cnt] <= INIT_VAL;
      end else if (w_write) begin
        for (int k = 0; k < NUM_BYTES; k++) begin
          if (bus.be[k]) begin
            r_mem[bus.addr][8*k +: 8] <= bus.data[8*k +: 8];
          end
        end
      end
    end
  end

  // Read return path: q holds between reads, q_valid pulses per accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= w_read;
      if (w_read) begin
        r_q <= r_mem[bus.addr];
      end
    end
  end

endmodule

// File: tb/tb_param_sync_ram.sv
// Directed testbench for param_sync_ram using three configurations:
// 16-bit with A5A5 clear sweep, 8-bit without sweep, 32-bit with byte enables.
module tb_param_sync_ram;

  logic clk;
  logic rstC;
  logic rstN;
  logic rstB;

  int nTests = 0;
  int nFail  = 0;

  param_sync_ram_if #(.DATA_W(16), .ADDR_W(6)) ifc ();
  param_sync_ram_if #(.DATA_W(8),  .ADDR_W(6)) ifn ();
  param_sync_ram_if #(.DATA_W(32), .ADDR_W(4)) ifb ();

  param_sync_ram #(
    .DATA_W(16), .ADDR_W(6), .CLEAR_ON_RESET(1), .INIT_VAL(16'hA5A5)
  ) uClr (.clk(clk), .rst(rstC), .bus(ifc));

  param_sync_ram #(
    .DATA_W(8), .ADDR_W(6), .CLEAR_ON_RESET(0), .INIT_VAL(8'h00)
  ) uNoClr (.clk(clk), .rst(rstN), .bus(ifn));

  param_sync_ram #(
    .DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(1), .INIT_VAL(32'h0)
  ) uBe (.clk(clk), .rst(rstB), .bus(ifb));

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wnr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        expValid;
    logic [31:0] expQ;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one table vector onto the 32-bit instance, clock it, compare.
  task automatic applyStimulus(input int i);
    ifb.req  = 1'b1;
    ifb.wnr  = vecs[i].wnr;
    ifb.addr = vecs[i].addr;
    ifb.data = vecs[i].data;
    ifb.be   = vecs[i].be;
    tick();
    checkOutput($sformatf("be_vec%0d_q_valid", i), 32'(ifb.q_valid), 32'(vecs[i].expValid));
    checkOutput($sformatf("be_vec%0d_q", i), ifb.q, vecs[i].expQ);
  endtask

  // Count cycles the 16-bit instance stays busy, bounded so it cannot hang.
  task automatic waitSweep(output int cycles);
    cycles = 0;
    while (ifc.busy === 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic readC(input logic [5:0] a);
    ifc.req  = 1'b1;
    ifc.wnr  = 1'b0;
    ifc.addr = a;
    tick();
    ifc.req  = 1'b0;
  endtask

  task automatic accessN(input logic w, input logic [5:0] a, input logic [7:0] d);
    ifn.req  = 1'b1;
    ifn.wnr  = w;
    ifn.addr = a;
    ifn.data = d;
    ifn.be   = 1'b1;
    tick();
    ifn.req  = 1'b0;
  endtask

  initial begin
    int cycles;
    int readyBad;
    int validBad;
    int dataBad;
    logic [7:0] expB;

    vecs[0]  = '{1'b1, 4'd5,  32'h11223344, 4'hF,    1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 4'd5,  32'hAABBCCDD, 4'b0101, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b0, 4'd5,  32'h0,        4'h0,    1'b1, 32'h11BB33DD};
    vecs[3]  = '{1'b1, 4'd5,  32'hFFFFFFFF, 4'h0,    1'b0, 32'h11BB33DD};
    vecs[4]  = '{1'b0, 4'd5,  32'h0,        4'h0,    1'b1, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 4'd6,  32'hCAFEBABE, 4'b1010, 1'b0, 32'h11BB33DD};
    vecs[6]  = '{1'b0, 4'd6,  32'h0,        4'h0,    1'b1, 32'hCA00BA00};
    vecs[7]  = '{1'b0, 4'd4,  32'h0,        4'h0,    1'b1, 32'h00000000};
    vecs[8]  = '{1'b1, 4'd15, 32'hDEADBEEF, 4'hF,    1'b0, 32'h00000000};
    vecs[9]  = '{1'b0, 4'd15, 32'h0,        4'h0,    1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 4'd0,  32'h12345678, 4'b1100, 1'b0, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 4'd0,  32'h0,        4'h0,    1'b1, 32'h12340000};

    ifc.req = 1'b0; ifc.wnr = 1'b0; ifc.addr = '0; ifc.data = '0; ifc.be = '0;
    ifn.req = 1'b0; ifn.wnr = 1'b0; ifn.addr = '0; ifn.data = '0; ifn.be = '0;
    ifb.req = 1'b0; ifb.wnr = 1'b0; ifb.addr = '0; ifb.data = '0; ifb.be = '0;
    rstC = 1'b1; rstN = 1'b1; rstB = 1'b1;
    repeat (3) tick();

    checkOutput("rst_clr_busy",    32'(ifc.busy),    32'd1);
    checkOutput("rst_clr_ready",   32'(ifc.ready),   32'd0);
    checkOutput("rst_clr_q",       32'(ifc.q),       32'd0);
    checkOutput("rst_clr_q_valid", 32'(ifc.q_valid), 32'd0);
    checkOutput("rst_nclr_busy",   32'(ifn.busy),    32'd0);
    checkOutput("rst_nclr_ready",  32'(ifn.ready),   32'd0);

    // Sweep with a write request held on the bus the whole time.
    rstC = 1'b0; rstN = 1'b0; rstB = 1'b0;
    ifc.req = 1'b1; ifc.wnr = 1'b1; ifc.addr = 6'd3; ifc.data = 16'h00FF; ifc.be = 2'b11;
    cycles = 0; readyBad = 0; validBad = 0;
    while (ifc.busy === 1'b1 && cycles < 200) begin
      if (ifc.ready !== 1'b0) readyBad++;
      if (ifc.q_valid !== 1'b0) validBad++;
      tick();
      cycles++;
    end
    ifc.req = 1'b0;
    checkOutput("clear_busy_cycles", 32'(cycles), 32'd64);
    checkOutput("clear_ready_low_cycles_bad", 32'(readyBad), 32'd0);
    checkOutput("clear_q_valid_cycles_bad", 32'(validBad), 32'd0);
    checkOutput("clear_ready_after", 32'(ifc.ready), 32'd1);
    checkOutput("nclr_ready_after", 32'(ifn.ready), 32'd1);
    checkOutput("be_inst_busy_after", 32'(ifb.busy), 32'd0);

    // Every word of the swept RAM reads INIT_VAL with one q_valid pulse.
    dataBad = 0; validBad = 0;
    for (int a = 0; a < 64; a++) begin
      readC(6'(a));
      if (ifc.q_valid !== 1'b1) validBad++;
      if (ifc.q !== 16'hA5A5) dataBad++;
      if (a == 3) checkOutput("clear_ignored_write_addr3", 32'(ifc.q), 32'h0000A5A5);
      tick();
      if (ifc.q_valid !== 1'b0) validBad++;
    end
    checkOutput("clear_readback_data_bad", 32'(dataBad), 32'd0);
    checkOutput("clear_readback_pulse_bad", 32'(validBad), 32'd0);

    // Fill 8-bit RAM then read back-to-back.
    for (int a = 0; a < 64; a++) accessN(1'b1, 6'(a), 8'(a + 2));
    checkOutput("fill_no_q_valid", 32'(ifn.q_valid), 32'd0);
    dataBad = 0; validBad = 0;
    ifn.req = 1'b1; ifn.wnr = 1'b0;
    for (int a = 0; a < 64; a++) begin
      ifn.addr = 6'(a);
      tick();
      expB = 8'(a + 2);
      if (ifn.q_valid !== 1'b1) validBad++;
      if (ifn.q !== expB) dataBad++;
    end
    ifn.req = 1'b0;
    checkOutput("fill_readback_data_bad", 32'(dataBad), 32'd0);
    checkOutput("fill_readback_valid_bad", 32'(validBad), 32'd0);
    tick();
    checkOutput("fill_valid_drop", 32'(ifn.q_valid), 32'd0);
    checkOutput("fill_q_hold", 32'(ifn.q), 32'd65);

    // Byte-enable table on the 32-bit instance, applied back-to-back.
    for (int i = 0; i < 12; i++) applyStimulus(i);
    ifb.req = 1'b0;
    tick();
    checkOutput("be_valid_drop", 32'(ifb.q_valid), 32'd0);

    // Write followed immediately by read of the same address.
    accessN(1'b1, 6'd10, 8'h7E);
    checkOutput("hazard_write_no_valid", 32'(ifn.q_valid), 32'd0);
    accessN(1'b0, 6'd10, 8'h00);
    checkOutput("hazard_read_valid", 32'(ifn.q_valid), 32'd1);
    checkOutput("hazard_read_q", 32'(ifn.q), 32'h7E);
    tick();
    checkOutput("hazard_idle_valid", 32'(ifn.q_valid), 32'd0);
    checkOutput("hazard_idle_q_hold", 32'(ifn.q), 32'h7E);

    // Write fields present but req low: memory must not change.
    ifn.req = 1'b0; ifn.wnr = 1'b1; ifn.addr = 6'd20; ifn.data = 8'h55; ifn.be = 1'b1;
    tick();
    accessN(1'b0, 6'd20, 8'h00);
    checkOutput("noreq_write_ignored", 32'(ifn.q), 32'd22);

    // Reset at sweep count 20 restarts the full sweep.
    rstC = 1'b1; tick(); rstC = 1'b0;
    repeat (20) tick();
    rstC = 1'b1; tick(); rstC = 1'b0;
    waitSweep(cycles);
    checkOutput("midsweep_rst_busy_cycles", 32'(cycles), 32'd64);
    checkOutput("midsweep_rst_ready", 32'(ifc.ready), 32'd1);

    // Reset on the edge after an accepted read kills q_valid and q.
    readC(6'd7);
    checkOutput("rdrst_read_valid", 32'(ifc.q_valid), 32'd1);
    checkOutput("rdrst_read_q", 32'(ifc.q), 32'h0000A5A5);
    rstC = 1'b1; tick(); rstC = 1'b0;
    checkOutput("rdrst_q_valid", 32'(ifc.q_valid), 32'd0);
    checkOutput("rdrst_q", 32'(ifc.q), 32'd0);
    checkOutput("rdrst_busy", 32'(ifc.busy), 32'd1);
    waitSweep(cycles);
    checkOutput("rdrst_sweep_cycles", 32'(cycles), 32'd64);

    // Write request coinciding with reset on the no-sweep instance.
    rstN = 1'b1;
    ifn.req = 1'b1; ifn.wnr = 1'b1; ifn.addr = 6'd20; ifn.data = 8'h99; ifn.be = 1'b1;
    tick();
    rstN = 1'b0; ifn.req = 1'b0;
    checkOutput("rstwr_ready_low", 32'(ifn.ready), 32'd0);
    checkOutput("rstwr_q_cleared", 32'(ifn.q), 32'd0);
    tick();
    checkOutput("rstwr_ready_up", 32'(ifn.ready), 32'd1);
    accessN(1'b0, 6'd20, 8'h00);
    checkOutput("rstwr_mem_unchanged", 32'(ifn.q), 32'd22);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
